// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared types and constants for the scan chain controller.
//   scan_state_t   : controller phase sequence for one scan test
//   SCAN_FILL      : value driven on scan-in whenever no pattern bit is due
//   is_shift_state : true for the phases in which the chain shifts (SE high)
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } scan_state_t;

    localparam logic SCAN_FILL = 1'b0;

    function automatic logic is_shift_state(input scan_state_t s);
        return (s == SHIFT_IN) || (s == SHIFT_OUT);
    endfunction

endpackage

// File: rtl/scan_bit_cnt.sv
// -----------------------------------------------------------------------------
// scan_bit_cnt
// Down-counter shared by the shift and capture phases. The FSM loads
// (phase length - 1) on entry to a phase and decrements once per cycle; tc_o
// marks the last cycle of the phase.
// Ports:
//   CLK, RSTB      clock, asynchronous active-low reset
//   clr_i          clear to zero (highest priority)
//   load_i         load load_val_i
//   load_val_i     value to load
//   dec_i          decrement by one (held at zero)
//   cnt_o          current count
//   tc_o           terminal count (count == 0)
// -----------------------------------------------------------------------------
module scan_bit_cnt #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequences one scan test per accepted start: shift a pattern into the chain,
// run functional capture cycles, shift the response out while comparing it
// bit by bit against a masked expected value.
// Ports:
//   CLK, RSTB        clock, asynchronous active-low reset (shared with chain)
//   start_i          request a test (accepted only in IDLE)
//   abort_i          cancel the running test (any non-IDLE state)
//   pattern_i        stimulus, bit j ends up in chain flop j
//   expected_i       expected captured value per flop
//   mask_i           1 = compare the bit, 0 = don't care
//   scan_so_i        Q of the last chain flop
//   scan_en_o        chain SE (registered)
//   scan_si_o        chain SI (registered)
//   busy_o           test in progress, through the DONE cycle
//   done_o           one-cycle pulse, results valid from this cycle
//   aborted_o        one-cycle pulse after an abort
//   response_o       captured chain contents
//   fail_count_o     number of masked mismatches
//   pass_o           fail_count_o == 0, updated at done
// -----------------------------------------------------------------------------
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = 8,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CHAIN_LEN-1:0] pattern_i,
    input  logic [CHAIN_LEN-1:0] expected_i,
    input  logic [CHAIN_LEN-1:0] mask_i,
    input  logic                 scan_so_i,
    output logic                 scan_en_o,
    output logic                 scan_si_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [CHAIN_LEN-1:0] response_o,
    output logic [CNT_W-1:0]     fail_count_o,
    output logic                 pass_o
);

    // The counter must hold both L-1 and CAP_CYCLES-1.
    localparam int CAP_W = $clog2(CAP_CYCLES + 1);
    localparam int CW    = (CNT_W > CAP_W) ? CNT_W : CAP_W;

    localparam logic [CW-1:0]    SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0]    CAP_LAST   = CW'(CAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAIL_MAX   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] FAIL_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    scan_state_t state_q, state_d;

    logic [CHAIN_LEN-1:0] pattern_q, expected_q, mask_q;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic [CNT_W-1:0]     fail_count_q, fail_count_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_si_q, scan_si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 pass_q, pass_d;

    logic                 accept_s;
    logic                 cnt_clr_s, cnt_load_s, cnt_dec_s;
    logic [CW-1:0]        cnt_load_val_s;
    logic [CW-1:0]        cnt_s;
    logic                 tc_s;
    logic [CHAIN_LEN-1:0] sel_cur_s;
    logic [CHAIN_LEN-1:0] sel_nxt_s;
    logic                 so_exp_s, so_msk_s;

    scan_bit_cnt #(
        .W (CW)
    ) u_bit_cnt (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .clr_i      (cnt_clr_s),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .dec_i      (cnt_dec_s),
        .cnt_o      (cnt_s),
        .tc_o       (tc_s)
    );

    // One-hot selects: current bit position (count) and the position the
    // next SHIFT_IN cycle will drive (count - 1, hence compare against j+1).
    always_comb begin
        sel_cur_s = {CHAIN_LEN{1'b0}};
        sel_nxt_s = {CHAIN_LEN{1'b0}};
        for (int j = 0; j < CHAIN_LEN; j++) begin
            sel_cur_s[j] = (cnt_s == CW'(j));
            sel_nxt_s[j] = (cnt_s == CW'(j + 1));
        end
    end

    // During SHIFT_OUT the counter value is directly the response bit index.
    assign so_exp_s = |(expected_q & sel_cur_s);
    assign so_msk_s = |(mask_q & sel_cur_s);

    // Next-state, counter control, result update and registered-output values.
    always_comb begin
        state_d        = state_q;
        accept_s       = 1'b0;
        cnt_clr_s      = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CW{1'b0}};
        cnt_dec_s      = 1'b0;
        response_d     = response_q;
        fail_count_d   = fail_count_q;
        pass_d         = pass_q;
        scan_si_d      = SCAN_FILL;
        aborted_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept_s       = 1'b1;
                    state_d        = SHIFT_IN;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SHIFT_LAST;
                    fail_count_d   = {CNT_W{1'b0}};
                    pass_d         = 1'b0;
                    // First bit in is the MSB so it travels to the far flop.
                    scan_si_d      = pattern_i[CHAIN_LEN-1];
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_IN: begin
                if (tc_s) begin
                    state_d        = CAPTURE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CAP_LAST;
                end else begin
                    cnt_dec_s = 1'b1;
                    scan_si_d = |(pattern_q & sel_nxt_s);
                end
            end
            CAPTURE: begin
                if (tc_s) begin
                    state_d        = SHIFT_OUT;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SHIFT_LAST;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            SHIFT_OUT: begin
                response_d = (response_q & ~sel_cur_s) |
                             (sel_cur_s & {CHAIN_LEN{scan_so_i}});
                if (so_msk_s && (scan_so_i != so_exp_s) && (fail_count_q != FAIL_MAX)) begin
                    fail_count_d = fail_count_q + FAIL_ONE;
                end else begin
                    fail_count_d = fail_count_q;
                end
                if (tc_s) begin
                    state_d   = DONE;
                    cnt_clr_s = 1'b1;
                    // Include the mismatch counted at this last edge.
                    pass_d    = (fail_count_d == {CNT_W{1'b0}});
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                cnt_clr_s = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase

        // Abort overrides every non-IDLE transition; partial results are kept.
        if (abort_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            cnt_clr_s    = 1'b1;
            cnt_load_s   = 1'b0;
            cnt_dec_s    = 1'b0;
            response_d   = response_q;
            fail_count_d = fail_count_q;
            pass_d       = 1'b0;
            scan_si_d    = SCAN_FILL;
            aborted_d    = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end

        scan_en_d = is_shift_state(state_d);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State, result and output registers.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= IDLE;
            response_q   <= {CHAIN_LEN{1'b0}};
            fail_count_q <= {CNT_W{1'b0}};
            pass_q       <= 1'b0;
            scan_en_q    <= 1'b0;
            scan_si_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            response_q   <= response_d;
            fail_count_q <= fail_count_d;
            pass_q       <= pass_d;
            scan_en_q    <= scan_en_d;
            scan_si_q    <= scan_si_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Test vectors are captured at acceptance and held for the whole test.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            pattern_q  <= {CHAIN_LEN{1'b0}};
            expected_q <= {CHAIN_LEN{1'b0}};
            mask_q     <= {CHAIN_LEN{1'b0}};
        end else if (accept_s) begin
            pattern_q  <= pattern_i;
            expected_q <= expected_i;
            mask_q     <= mask_i;
        end else begin
            pattern_q  <= pattern_q;
            expected_q <= expected_q;
            mask_q     <= mask_q;
        end
    end

    assign scan_en_o    = scan_en_q;
    assign scan_si_o    = scan_si_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign response_o   = response_q;
    assign fail_count_o = fail_count_q;
    assign pass_o       = pass_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Two controllers (CAP_CYCLES=1 and 3), each driving a behavioural 8-flop
// scan chain with a functional logic stub (identity / invert / +1 counter).
// Expected outputs come from a cycle-indexed timeline and from applying the
// stub function to the pattern, not from the controller's internals.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

    localparam int L = 8;

    logic       CLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [7:0] expected = 8'h00;
    logic [7:0] mask = 8'h00;
    int         mode_a = 0;
    logic       sel = 1'b0;

    logic       so_a, en_a, si_a, busy_a, done_a, ab_a, pass_a;
    logic       so_b, en_b, si_b, busy_b, done_b, ab_b, pass_b;
    logic [7:0] resp_a, resp_b, chain_a, chain_b;
    logic [3:0] fail_a, fail_b;

    int checks = 0;
    int failures = 0;
    int dseen;

    always #5 CLK = ~CLK;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut_a (
        .CLK(CLK), .RSTB(RSTB), .start_i(start_a), .abort_i(abort),
        .pattern_i(pattern), .expected_i(expected), .mask_i(mask),
        .scan_so_i(so_a), .scan_en_o(en_a), .scan_si_o(si_a),
        .busy_o(busy_a), .done_o(done_a), .aborted_o(ab_a),
        .response_o(resp_a), .fail_count_o(fail_a), .pass_o(pass_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(3)) dut_b (
        .CLK(CLK), .RSTB(RSTB), .start_i(start_b), .abort_i(1'b0),
        .pattern_i(pattern), .expected_i(expected), .mask_i(mask),
        .scan_so_i(so_b), .scan_en_o(en_b), .scan_si_o(si_b),
        .busy_o(busy_b), .done_o(done_b), .aborted_o(ab_b),
        .response_o(resp_b), .fail_count_o(fail_b), .pass_o(pass_b)
    );

    // Functional logic stub: 0 identity, 1 invert, 2 increment.
    function automatic logic [7:0] stub(input int m, input logic [7:0] x);
        if (m == 1) return ~x;
        else if (m == 2) return x + 8'd1;
        else return x;
    endfunction

    // Behavioural scan chains: flop 0 nearest SI, SO from flop 7.
    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) chain_a <= 8'h00;
        else if (en_a) chain_a <= {chain_a[6:0], si_a};
        else chain_a <= stub(mode_a, chain_a);
    end
    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) chain_b <= 8'h00;
        else if (en_b) chain_b <= {chain_b[6:0], si_b};
        else chain_b <= stub(2, chain_b);
    end
    assign so_a = chain_a[7];
    assign so_b = chain_b[7];

    // View of whichever controller the current test targets.
    logic       o_en, o_si, o_busy, o_done, o_ab, o_pass;
    logic [7:0] o_resp;
    logic [3:0] o_fail;
    assign o_en   = sel ? en_b   : en_a;
    assign o_si   = sel ? si_b   : si_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_ab   = sel ? ab_b   : ab_a;
    assign o_pass = sel ? pass_b : pass_a;
    assign o_resp = sel ? resp_b : resp_a;
    assign o_fail = sel ? fail_b : fail_a;

    function automatic logic [7:0] model_resp(input int m, input logic [7:0] p, input int n);
        logic [7:0] v;
        v = p;
        for (int i = 0; i < n; i++) v = stub(m, v);
        return v;
    endfunction

    function automatic int popc(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One test: start at edge 0, then compare every cycle up to T+2.
    // abort_cyc / restart_cyc / rst_cyc = 0 disables that disturbance.
    task automatic run_test(input bit s, input int cap, input logic [7:0] p,
                            input logic [7:0] e, input logic [7:0] m, input int mode,
                            input int abort_cyc, input int restart_cyc, input int rst_cyc,
                            output int done_seen);
        int T;
        logic [7:0] er;
        int ef;
        logic [4:0] es;
        bit gone;
        T = 2 * L + cap + 1;
        er = model_resp(s ? 2 : mode, p, cap);
        ef = popc((er ^ e) & m);
        done_seen = -1;
        @(negedge CLK);
        sel = s;
        if (!s) mode_a = mode;
        pattern = p; expected = e; mask = m;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= T + 2; c++) begin
            @(negedge CLK);
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
            gone = (abort_cyc > 0) && (c > abort_cyc);
            if (!gone) begin
                es[4] = ((c >= 1) && (c <= L)) || ((c >= L + cap + 1) && (c <= 2 * L + cap));
                es[3] = ((c >= 1) && (c <= L)) ? p[L - c] : 1'b0;
                es[2] = (c >= 1) && (c <= T);
                es[1] = (c == T);
                es[0] = 1'b0;
            end else begin
                es = {4'b0000, (c == abort_cyc + 1)};
            end
            chk($sformatf("status_c%0d", c), {27'd0, o_en, o_si, o_busy, o_done, o_ab}, {27'd0, es});
            if (o_done && done_seen < 0) done_seen = c;
            if (c == T && !gone) begin
                chk("response", {24'd0, o_resp}, {24'd0, er});
                chk("fail_count", {28'd0, o_fail}, ef);
                chk("pass", {31'd0, o_pass}, {31'd0, (ef == 0)});
            end
            if (abort_cyc > 0 && c == abort_cyc + 1)
                chk("pass_after_abort", {31'd0, o_pass}, 32'd0);
            if (c == rst_cyc) begin
                RSTB = 1'b0;
                #1;
                chk("reset_mid_test", {10'd0, o_en, o_si, o_busy, o_done, o_ab, o_pass, o_resp, o_fail}, 32'd0);
                @(negedge CLK);
                RSTB = 1'b1;
                return;
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == restart_cyc) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
                pattern = ~p; expected = ~e;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("reset_a", {10'd0, en_a, si_a, busy_a, done_a, ab_a, pass_a, resp_a, fail_a}, 32'd0);
        chk("reset_b", {10'd0, en_b, si_b, busy_b, done_b, ab_b, pass_b, resp_b, fail_b}, 32'd0);
        RSTB = 1'b1;
        @(negedge CLK);

        // Pin the model itself.
        chk("model_invert", {24'd0, model_resp(1, 8'h3C, 1)}, 32'h0000_00C3);
        chk("model_popc", popc((8'hC3 ^ 8'hC0) & 8'hFF), 32'd2);

        // Identity A5: SI sequence from the timeline, done in cycle 18.
        run_test(1'b0, 1, 8'hA5, 8'hA5, 8'hFF, 0, 0, 0, 0, dseen);
        chk("lit_resp_a5", {24'd0, resp_a}, 32'h0000_00A5);
        chk("lit_done_cycle_18", dseen, 32'd18);

        // Inverting stub: exact match, two mismatches, masked-off mismatches.
        run_test(1'b0, 1, 8'h3C, 8'hC3, 8'hFF, 1, 0, 0, 0, dseen);
        chk("lit_resp_c3", {24'd0, resp_a}, 32'h0000_00C3);
        run_test(1'b0, 1, 8'h3C, 8'hC0, 8'hFF, 1, 0, 0, 0, dseen);
        chk("lit_fail_2", {28'd0, fail_a}, 32'd2);
        chk("lit_pass_0", {31'd0, pass_a}, 32'd0);
        run_test(1'b0, 1, 8'h3C, 8'hC0, 8'hFC, 1, 0, 0, 0, dseen);

        // start re-pulsed in SHIFT_OUT is ignored, then a fresh start works.
        run_test(1'b0, 1, 8'hA5, 8'hA5, 8'hFF, 0, 0, 12, 0, dseen);
        chk("single_done", dseen, 32'd18);
        run_test(1'b0, 1, 8'h96, 8'h96, 8'hFF, 0, 0, 0, 0, dseen);

        // Abort in cycle 5, then a clean test.
        run_test(1'b0, 1, 8'hA5, 8'hA5, 8'hFF, 0, 5, 0, 0, dseen);
        chk("no_done_after_abort", dseen, 32'hFFFF_FFFF);
        run_test(1'b0, 1, 8'h3C, 8'h00, 8'h00, 1, 0, 0, 0, dseen);

        // Abort in the DONE cycle: done already seen, pass cleared after.
        run_test(1'b0, 1, 8'h5A, 8'h5A, 8'hFF, 0, 18, 0, 0, dseen);

        // Reset during CAPTURE, then a full A5 test.
        run_test(1'b0, 1, 8'hA5, 8'hA5, 8'hFF, 0, 0, 0, 9, dseen);
        run_test(1'b0, 1, 8'hA5, 8'hA5, 8'hFF, 0, 0, 0, 0, dseen);
        chk("lit_pass_after_reset", {31'd0, pass_a}, 32'd1);

        // CAP_CYCLES=3 with the counting stub.
        run_test(1'b1, 3, 8'h5A, 8'h5D, 8'hFF, 2, 0, 0, 0, dseen);
        chk("lit_done_cycle_20", dseen, 32'd20);
        chk("lit_resp_5d", {24'd0, resp_b}, 32'h0000_005D);
        run_test(1'b1, 3, 8'hFF, 8'h00, 8'h0F, 2, 0, 0, 0, dseen);
        chk("lit_fail_wrap", {28'd0, fail_b}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
